// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length/words/checksum byte stream and writes each word to instruction memory.
// Latency: a write pulse comes one cycle after its DATA_LO byte; done/error come one cycle after the checksum byte.
// Backpressure: rx_ready stays high while loading and drops for good in DONE or ERR.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [15:0]           imem_addr,
  output logic [15:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [7:0]          hi_q, hi_d;
  logic [7:0]          csum_q, csum_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [15:0]         addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;

  logic                accept;
  logic [15:0]         new_len;

  // Status outputs decode directly from the state register.
  assign done         = (state_q == S_DONE);
  assign error        = (state_q == S_ERR);
  assign cpu_reset    = (state_q != S_DONE);
  assign rx_ready     = !((state_q == S_DONE) || (state_q == S_ERR));
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign words_loaded = cnt_q;

  assign accept  = rx_valid && rx_ready;
  assign new_len = {len_q[15:8], rx_data};

  // Next-state logic: every transition and datapath update is gated by an accepted byte.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    hi_d    = hi_q;
    csum_d  = csum_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept) begin
      // The checksum byte itself is not folded into the running XOR.
      if (state_q != S_CSUM) begin
        csum_d = csum_q ^ rx_data;
      end
      case (state_q)
        S_LEN_HI: begin
          len_d[15:8] = rx_data;
          state_d     = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d = new_len;
          if ({16'd0, new_len} > 32'(DEPTH)) begin
            state_d = S_ERR;
          end else if (new_len == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          hi_d    = rx_data;
          state_d = S_DATA_LO;
        end
        S_DATA_LO: begin
          // Word index is the low bits of the count; it never wraps because N <= DEPTH.
          we_d    = 1'b1;
          wdata_d = {hi_q, rx_data};
          addr_d  = 16'({cnt_q[ADDR_WIDTH-1:0], 1'b0});
          cnt_d   = cnt_q + (ADDR_WIDTH+1)'(1);
          state_d = (16'(cnt_d) == len_q) ? S_CSUM : S_DATA_HI;
        end
        S_CSUM: begin
          state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State and datapath registers; reset also drops any write pulse computed on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_LEN_HI;
      len_q   <= '0;
      hi_q    <= '0;
      csum_q  <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      hi_q    <= hi_d;
      csum_q  <= csum_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: table of byte-stream vectors plus hand-written
// sequences for a full-depth load, reset during a load, and reset while in DONE.
module tb_imem_boot_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          imem_we;
  logic [15:0]   imem_addr;
  logic [15:0]   imem_wdata;
  logic          cpu_reset;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  int checks = 0;
  int errors = 0;

  logic [31:0] wq[$];

  imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
    .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Capture every write pulse, sampled mid-cycle, and watch for done/error together.
  always @(negedge clk) begin
    if (imem_we === 1'b1) wq.push_back({imem_addr, imem_wdata});
    if (done === 1'b1 && error === 1'b1) begin
      errors++;
      $display("FAIL done_and_error: done=%b error=%b required not both 1", done, error);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    rx_data  = 8'hEE;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic present(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'hEE;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rx_ready"},  32'(rx_ready), 32'd1);
    chk({tag, "_imem_we"},   32'(imem_we), 32'd0);
    chk({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_imem_wdata"},32'(imem_wdata), 32'd0);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    chk({tag, "_done"},      32'(done), 32'd0);
    chk({tag, "_error"},     32'(error), 32'd0);
    chk({tag, "_words"},     32'(words_loaded), 32'd0);
  endtask

  typedef struct packed {
    logic [0:8][7:0] bytes;
    logic [3:0]      n;
    logic [1:0]      gap;      // 0 back-to-back, 1 alternate idle, 2 random idle 0..3
    logic [3:0]      exp_writes;
    logic [31:0]     exp_w0;   // {addr, data}
    logic [31:0]     exp_w1;
    logic            exp_done;
    logic            exp_err;
    logic [15:0]     exp_words;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [7:0]  cs;
    logic [15:0] w;
    logic [31:0] last;

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_reset_state("reset");

    vecs[0] = '{bytes: {8'h00,8'h02,8'h12,8'h34,8'hAB,8'hCD,8'h42,8'h00,8'h00}, n: 4'd7, gap: 2'd0,
                exp_writes: 4'd2, exp_w0: 32'h0000_1234, exp_w1: 32'h0002_ABCD,
                exp_done: 1'b1, exp_err: 1'b0, exp_words: 16'd2};
    vecs[1] = '{bytes: {8'h00,8'h02,8'h12,8'h34,8'hAB,8'hCD,8'h43,8'h55,8'h66}, n: 4'd9, gap: 2'd0,
                exp_writes: 4'd2, exp_w0: 32'h0000_1234, exp_w1: 32'h0002_ABCD,
                exp_done: 1'b0, exp_err: 1'b1, exp_words: 16'd2};
    vecs[2] = '{bytes: {8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, n: 4'd3, gap: 2'd0,
                exp_writes: 4'd0, exp_w0: 32'h0, exp_w1: 32'h0,
                exp_done: 1'b1, exp_err: 1'b0, exp_words: 16'd0};
    vecs[3] = '{bytes: {8'h01,8'h01,8'h12,8'h34,8'h56,8'h78,8'h00,8'h00,8'h00}, n: 4'd6, gap: 2'd0,
                exp_writes: 4'd0, exp_w0: 32'h0, exp_w1: 32'h0,
                exp_done: 1'b0, exp_err: 1'b1, exp_words: 16'd0};
    vecs[4] = vecs[0];
    vecs[4].gap = 2'd1;
    vecs[5] = vecs[0];
    vecs[5].gap = 2'd2;

    for (int v = 0; v < 6; v++) begin
      do_reset();
      wq.delete();
      for (int i = 0; i < int'(vecs[v].n); i++) begin
        present(vecs[v].bytes[i]);
        if (vecs[v].gap == 2'd1) idle(1);
        else if (vecs[v].gap == 2'd2) idle($urandom_range(0, 3));
      end
      idle(2);
      chk($sformatf("v%0d_nwrites", v), 32'(wq.size()), 32'(vecs[v].exp_writes));
      if (vecs[v].exp_writes > 0 && wq.size() > 0) chk($sformatf("v%0d_write0", v), wq[0], vecs[v].exp_w0);
      if (vecs[v].exp_writes > 1 && wq.size() > 1) chk($sformatf("v%0d_write1", v), wq[1], vecs[v].exp_w1);
      last = (vecs[v].exp_writes > 1) ? vecs[v].exp_w1 : vecs[v].exp_w0;
      chk($sformatf("v%0d_addr_hold", v),  32'(imem_addr),  32'(last[31:16]));
      chk($sformatf("v%0d_wdata_hold", v), 32'(imem_wdata), 32'(last[15:0]));
      chk($sformatf("v%0d_done", v),       32'(done),      32'(vecs[v].exp_done));
      chk($sformatf("v%0d_error", v),      32'(error),     32'(vecs[v].exp_err));
      chk($sformatf("v%0d_cpu_reset", v),  32'(cpu_reset), 32'(!vecs[v].exp_done));
      chk($sformatf("v%0d_rx_ready", v),   32'(rx_ready),  32'd0);
      chk($sformatf("v%0d_words", v),      32'(words_loaded), 32'(vecs[v].exp_words));
    end

    // Full-depth image: N == DEPTH == 256, word i = {i ^ 0xC3, i}.
    do_reset();
    wq.delete();
    cs = 8'h01 ^ 8'h00;
    present(8'h01);
    present(8'h00);
    chk("full_not_err_after_len", 32'(error), 32'd0);
    for (int i = 0; i < 256; i++) begin
      w = {8'(i) ^ 8'hC3, 8'(i)};
      cs = cs ^ w[15:8] ^ w[7:0];
      present(w[15:8]);
      present(w[7:0]);
    end
    present(cs);
    idle(1);
    chk("full_nwrites", 32'(wq.size()), 32'd256);
    if (wq.size() == 256) begin
      chk("full_first", wq[0],   32'h0000_C300);
      chk("full_mid",   wq[100], 32'h00C8_A764);
      chk("full_last",  wq[255], 32'h01FE_3CFF);
    end
    chk("full_done",  32'(done), 32'd1);
    chk("full_words", 32'(words_loaded), 32'd256);

    // Reset arrives on the same edge as the second word's low byte: that write must not happen.
    do_reset();
    wq.delete();
    present(8'h00); present(8'h02); present(8'h12); present(8'h34); present(8'hAB);
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hCD;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    rx_valid = 1'b0;
    idle(2);
    chk("midreset_nwrites", 32'(wq.size()), 32'd1);
    chk_reset_state("midreset");
    wq.delete();
    present(8'h00); present(8'h02); present(8'h12); present(8'h34);
    present(8'hAB); present(8'hCD); present(8'h42);
    chk("reload_done", 32'(done), 32'd1);
    chk("reload_nwrites", 32'(wq.size()), 32'd2);
    if (wq.size() == 2) begin
      chk("reload_write0", wq[0], 32'h0000_1234);
      chk("reload_write1", wq[1], 32'h0002_ABCD);
    end

    // Reset while in DONE returns the core to reset and restarts the loader.
    do_reset();
    chk_reset_state("donereset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
